// File: rtl/ppu_pkg.sv
// Shared definitions for the PPU write scheduler: scheduler states,
// host address regions and control-register bit positions.
package ppu_pkg;

    // Scheduler state: IDLE (nothing committed), ARMED (batch waiting for
    // the blanking window), DRAIN (batch popping inside the window).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2
    } ppu_state_e;

    // Host address regions, selected by av_address[9:8].
    localparam logic [1:0] ATTR   = 2'b00;
    localparam logic [1:0] SPRITE = 2'b01;
    localparam logic [1:0] COLOR  = 2'b10;
    localparam logic [1:0] CTRL   = 2'b11;

    // Control-register write fields.
    localparam int CTRL_IMM_BIT    = 0;  // immediate-mode enable (sticky)
    localparam int CTRL_COMMIT_BIT = 1;  // commit strobe (self-clearing)

    // One queued entry is {address, data}.
    localparam int ENTRY_W = 48;

    // True when the host address targets the control register rather than
    // one of the queued PPU regions.
    function automatic logic is_ctrl_addr(input logic [15:0] addr);
        return addr[9:8] == CTRL;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port. The read register only
// updates on a pop, so it doubles as a "last value popped" holding register.
module sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = rd_data_q;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Next-state for pointers, level and read register; pointers wrap
    // naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d  = rd_ptr_q + AW'(1);
            rd_data_d = mem[rd_ptr_q];
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage array write port; no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Control registers and the read holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/ppu_write_sched.sv
// Buffers host writes to the PPU and releases committed batches only during
// vertical blank (or immediately, when immediate mode is enabled).
module ppu_write_sched
    import ppu_pkg::*;
#(
    parameter int         DEPTH   = 8,
    parameter logic [9:0] VACTIVE = 10'd480,
    localparam int        LW      = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          av_chipselect,
    input  logic          av_write,
    input  logic [15:0]   av_address,
    input  logic [31:0]   av_writedata,
    output logic          av_waitrequest,
    input  logic [9:0]    vcount,
    output logic          ppu_chipselect,
    output logic          ppu_write,
    output logic [15:0]   ppu_address,
    output logic [31:0]   ppu_writedata,
    output logic [LW-1:0] fifo_level,
    output logic          frame_done
);

    logic               host_req;
    logic               ctrl_sel;
    logic               ctrl_wr;
    logic               queued_req;
    logic               push;
    logic               pop;
    logic               commit;
    logic               in_window;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_rd_data;
    logic [LW-1:0]      eligible;
    ppu_state_e         state;

    logic [LW-1:0]      commit_left_q, commit_left_d;
    logic               imm_q, imm_d;
    logic               drained_q, drained_d;
    logic               frame_done_q, frame_done_d;
    logic               strobe_q, strobe_d;

    assign host_req   = av_chipselect & av_write;
    assign ctrl_sel   = is_ctrl_addr(av_address);
    assign ctrl_wr    = host_req & ctrl_sel;
    assign queued_req = host_req & ~ctrl_sel;
    assign push       = queued_req & ~fifo_full;
    assign commit     = ctrl_wr & av_writedata[CTRL_COMMIT_BIT];
    assign in_window  = (vcount >= VACTIVE);

    // Control writes are always accepted; only queued writes see back-pressure.
    assign av_waitrequest = queued_req & fifo_full;

    // Entries a commit would capture: what is queued now minus this cycle's
    // pop; a same-cycle push belongs to the next batch.
    assign eligible = fifo_level - LW'(pop);

    // State is fully determined by the outstanding batch and the window.
    always_comb begin
        if (commit_left_q == '0) begin
            state = IDLE;
        end else if (in_window) begin
            state = DRAIN;
        end else begin
            state = ARMED;
        end
    end

    // Pop whenever something is queued and either immediate mode or a
    // committed batch inside the window allows it.
    assign pop = ~fifo_empty & (imm_q | (state == DRAIN));

    // Batch bookkeeping, immediate-mode flag and the done pulse.
    always_comb begin
        commit_left_d = commit_left_q;
        imm_d         = imm_q;
        drained_d     = 1'b0;
        frame_done_d  = drained_q;
        strobe_d      = pop;
        if (ctrl_wr) begin
            imm_d = av_writedata[CTRL_IMM_BIT];
        end
        if (commit) begin
            commit_left_d = eligible;
            if (eligible == '0) begin
                frame_done_d = 1'b1;
            end
        end else if (pop && (commit_left_q != '0)) begin
            commit_left_d = commit_left_q - LW'(1);
            drained_d     = (commit_left_q == LW'(1));
        end
    end

    // Scheduler registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            commit_left_q <= '0;
            imm_q         <= 1'b0;
            drained_q     <= 1'b0;
            frame_done_q  <= 1'b0;
            strobe_q      <= 1'b0;
        end else begin
            commit_left_q <= commit_left_d;
            imm_q         <= imm_d;
            drained_q     <= drained_d;
            frame_done_q  <= frame_done_d;
            strobe_q      <= strobe_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data ({av_address, av_writedata}),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // The FIFO read register holds the last popped entry, which is exactly
    // the "hold last value" behaviour wanted on the PPU address/data bus.
    assign ppu_chipselect = strobe_q;
    assign ppu_write      = strobe_q;
    assign ppu_address    = fifo_rd_data[47:32];
    assign ppu_writedata  = fifo_rd_data[31:0];
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_ppu_write_sched.sv
// Directed bench for ppu_write_sched: a queue-based reference model checked
// every cycle, plus hand-computed checks for each scenario.
module tb_ppu_write_sched;

    localparam int         DEPTH   = 8;
    localparam logic [9:0] VACTIVE = 10'd480;
    localparam int         LW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          av_chipselect = 1'b0;
    logic          av_write = 1'b0;
    logic [15:0]   av_address = '0;
    logic [31:0]   av_writedata = '0;
    logic          av_waitrequest;
    logic [9:0]    vcount = '0;
    logic          ppu_chipselect;
    logic          ppu_write;
    logic [15:0]   ppu_address;
    logic [31:0]   ppu_writedata;
    logic [LW-1:0] fifo_level;
    logic          frame_done;

    ppu_write_sched #(.DEPTH(DEPTH), .VACTIVE(VACTIVE)) dut (
        .clk            (clk),
        .reset          (reset),
        .av_chipselect  (av_chipselect),
        .av_write       (av_write),
        .av_address     (av_address),
        .av_writedata   (av_writedata),
        .av_waitrequest (av_waitrequest),
        .vcount         (vcount),
        .ppu_chipselect (ppu_chipselect),
        .ppu_write      (ppu_write),
        .ppu_address    (ppu_address),
        .ppu_writedata  (ppu_writedata),
        .fifo_level     (fifo_level),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [47:0] act, logic [47:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // The queue holds pending entries; m_batch is how many at its head belong
    // to the committed batch still to be delivered.
    logic [47:0] mq[$];
    int          m_batch = 0;
    bit          m_imm = 0;
    bit          m_done_next = 0;
    bit          exp_cs = 0;
    bit          exp_fd = 0;
    logic [15:0] exp_addr = '0;
    logic [31:0] exp_data = '0;

    always @(posedge clk or posedge reset) begin : model
        bit          win, req, ctrl, pop_now, push_now, commit;
        int          avail;
        logic [47:0] e;
        if (reset) begin
            mq.delete();
            m_batch = 0; m_imm = 0; m_done_next = 0;
            exp_cs = 0; exp_fd = 0; exp_addr = '0; exp_data = '0;
        end else begin
            win      = (vcount >= VACTIVE);
            req      = av_chipselect && av_write;
            ctrl     = (av_address[9:8] == 2'b11);
            pop_now  = (mq.size() != 0) && (m_imm || (m_batch > 0 && win));
            push_now = req && !ctrl && (mq.size() < DEPTH);
            commit   = req && ctrl && av_writedata[1];
            avail    = mq.size() - (pop_now ? 1 : 0);
            exp_fd   = m_done_next || (commit && avail == 0);
            m_done_next = pop_now && (m_batch == 1) && !commit;
            if (commit) m_batch = avail;
            else if (pop_now && m_batch > 0) m_batch = m_batch - 1;
            if (req && ctrl) m_imm = av_writedata[0];
            exp_cs = pop_now;
            if (pop_now) begin
                e = mq.pop_front();
                exp_addr = e[47:32];
                exp_data = e[31:0];
            end
            if (push_now) mq.push_back({av_address, av_writedata});
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("ppu_chipselect", 48'(ppu_chipselect), 48'(exp_cs));
        chk("ppu_write", 48'(ppu_write), 48'(exp_cs));
        chk("ppu_address", 48'(ppu_address), 48'(exp_addr));
        chk("ppu_writedata", 48'(ppu_writedata), 48'(exp_data));
        chk("fifo_level", 48'(fifo_level), 48'(mq.size()));
        chk("frame_done", 48'(frame_done), 48'(exp_fd));
        chk("av_waitrequest", 48'(av_waitrequest),
            48'(av_chipselect && av_write && av_address[9:8] != 2'b11 && mq.size() == DEPTH));
    end

    // ---------------- event log ----------------
    logic [15:0] s_addr[$];
    int          s_cyc[$];
    int          fd_cyc[$];
    int          wait_seen = 0;

    always @(negedge clk) begin
        if (ppu_chipselect === 1'b1) begin
            s_addr.push_back(ppu_address);
            s_cyc.push_back(cyc);
            $display("strobe cyc=%0d addr=%h data=%h", cyc, ppu_address, ppu_writedata);
        end
        if (frame_done === 1'b1) begin
            fd_cyc.push_back(cyc);
            $display("frame_done cyc=%0d", cyc);
        end
        if (av_waitrequest === 1'b1) wait_seen++;
    end

    task automatic clear_logs();
        s_addr.delete(); s_cyc.delete(); fd_cyc.delete(); wait_seen = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Issue one host write and hold it until accepted; acc_cyc is the cycle
    // in which the request was seen without waitrequest.
    task automatic host_write(input logic [15:0] a, input logic [31:0] d, output int acc_cyc);
        int budget;
        bit w;
        bit done;
        av_chipselect = 1'b1; av_write = 1'b1; av_address = a; av_writedata = d;
        budget = 0; done = 0; acc_cyc = -1;
        while (!done && budget < 200) begin
            @(negedge clk);
            w = av_waitrequest;
            acc_cyc = cyc;
            @(posedge clk);
            #2;
            if (!w) done = 1;
            budget++;
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL host_write_timeout addr=%h actual=stalled required=accepted", a);
        end
        $display("host write addr=%h data=%h acc_cyc=%0d", a, d, acc_cyc);
        av_chipselect = 1'b0; av_write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int acc;
        int acc9;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        chk("rst_level", 48'(fifo_level), 48'd0);
        chk("rst_addr", 48'(ppu_address), 48'd0);
        chk("rst_data", 48'(ppu_writedata), 48'd0);
        chk("rst_cs", 48'(ppu_chipselect), 48'd0);

        // Three writes, commit outside the window, drain at vcount=480
        vcount = 10'd100; clear_logs();
        host_write(16'h0001, 32'h1111_0001, acc);
        host_write(16'h0102, 32'h1111_0102, acc);
        host_write(16'h0203, 32'h1111_0203, acc);
        chk("s1_level", 48'(fifo_level), 48'd3);
        host_write(16'h0300, 32'h2, acc);
        tick(5);
        chk("s1_no_strobe_armed", 48'(s_addr.size()), 48'd0);
        vcount = 10'd480;
        tick(6);
        chk("s1_strobes", 48'(s_addr.size()), 48'd3);
        chk("s1_addr0", 48'(s_addr[0]), 48'h0001);
        chk("s1_addr1", 48'(s_addr[1]), 48'h0102);
        chk("s1_addr2", 48'(s_addr[2]), 48'h0203);
        chk("s1_consecutive", 48'(s_cyc[2] - s_cyc[0]), 48'd2);
        chk("s1_fd_count", 48'(fd_cyc.size()), 48'd1);
        chk("s1_fd_timing", 48'(fd_cyc[0]), 48'(s_cyc[2] + 1));
        chk("s1_level_end", 48'(fifo_level), 48'd0);

        // Full FIFO plus a 9th write stalls until the first pop
        do_reset(); vcount = 10'd100; clear_logs();
        for (int i = 0; i < 8; i++) host_write(16'h0010 + 16'(i), 32'hB000_0000 + i, acc);
        chk("s2_full_level", 48'(fifo_level), 48'd8);
        host_write(16'h0300, 32'h2, acc);
        wait_seen = 0;
        fork
            host_write(16'h0018, 32'hB000_0008, acc9);
            begin
                tick(3);
                vcount = 10'd480;
                tick(1);
                vcount = 10'd100;
            end
        join
        chk("s2_wait_cycles", 48'(wait_seen), 48'd4);
        chk("s2_level_back", 48'(fifo_level), 48'd8);
        chk("s2_one_pop", 48'(s_addr.size()), 48'd1);
        chk("s2_first_addr", 48'(s_addr[0]), 48'h0010);
        chk("s2_accept_at_pop", 48'(acc9), 48'(s_cyc[0]));
        vcount = 10'd480;
        tick(12);
        chk("s2_batch_pops", 48'(s_addr.size()), 48'd8);
        chk("s2_last_addr", 48'(s_addr[7]), 48'h0017);
        chk("s2_left_over", 48'(fifo_level), 48'd1);
        chk("s2_fd_count", 48'(fd_cyc.size()), 48'd1);

        // Window closes after two pops; rest drains in the next window
        do_reset(); vcount = 10'd100; clear_logs();
        for (int i = 0; i < 5; i++) host_write(16'h0020 + 16'(i), 32'hC000_0000 + i, acc);
        host_write(16'h0300, 32'h2, acc);
        vcount = 10'd480;
        tick(2);
        vcount = 10'd0;
        tick(4);
        chk("s3_level_armed", 48'(fifo_level), 48'd3);
        chk("s3_two_pops", 48'(s_addr.size()), 48'd2);
        chk("s3_no_fd_yet", 48'(fd_cyc.size()), 48'd0);
        vcount = 10'd480;
        tick(6);
        chk("s3_all_pops", 48'(s_addr.size()), 48'd5);
        chk("s3_addr2", 48'(s_addr[2]), 48'h0022);
        chk("s3_addr4", 48'(s_addr[4]), 48'h0024);
        chk("s3_fd_count", 48'(fd_cyc.size()), 48'd1);
        chk("s3_level_end", 48'(fifo_level), 48'd0);

        // Immediate mode: strobe two cycles after acceptance, no commit
        do_reset(); vcount = 10'd100; clear_logs();
        host_write(16'h0300, 32'h1, acc);
        host_write(16'h0205, 32'hC0DE_0205, acc);
        tick(3);
        chk("s4_one_strobe", 48'(s_addr.size()), 48'd1);
        chk("s4_addr", 48'(s_addr[0]), 48'h0205);
        chk("s4_latency", 48'(s_cyc[0]), 48'(acc + 2));
        chk("s4_no_fd", 48'(fd_cyc.size()), 48'd0);
        host_write(16'h0300, 32'h0, acc);

        // Commit with nothing queued
        do_reset(); clear_logs();
        host_write(16'h0300, 32'h2, acc);
        tick(3);
        chk("s5_fd_count", 48'(fd_cyc.size()), 48'd1);
        chk("s5_fd_timing", 48'(fd_cyc[0]), 48'(acc + 1));
        chk("s5_no_strobe", 48'(s_addr.size()), 48'd0);

        // Reset mid-drain with four entries left
        do_reset(); vcount = 10'd100; clear_logs();
        for (int i = 0; i < 6; i++) host_write(16'h0030 + 16'(i), 32'hD000_0000 + i, acc);
        host_write(16'h0300, 32'h2, acc);
        vcount = 10'd480;
        tick(2);
        chk("s6_level_before", 48'(fifo_level), 48'd4);
        #1 reset = 1'b1;
        #1;
        chk("s6_rst_level", 48'(fifo_level), 48'd0);
        chk("s6_rst_cs", 48'(ppu_chipselect), 48'd0);
        chk("s6_rst_addr", 48'(ppu_address), 48'd0);
        chk("s6_rst_data", 48'(ppu_writedata), 48'd0);
        chk("s6_rst_fd", 48'(frame_done), 48'd0);
        clear_logs();
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("s6_no_strobe", 48'(s_addr.size()), 48'd0);
        chk("s6_level_after", 48'(fifo_level), 48'd0);
        vcount = 10'd0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ppu_write_sched.md
PPU_WRITE_SCHED -- requirements
Module: ppu_write_sched

Interface
REQ-001 Parameter DEPTH, default 8, write-FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Parameter VACTIVE, default 10'd480, first vertical-blank line.
REQ-003 clk  input  1  system clock, 50 MHz, shared with ppu.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 av_chipselect  input  1  host select.
REQ-006 av_write  input  1  host write strobe.
REQ-007 av_address  input  16  host word address.
REQ-008 av_writedata  input  32  host write data.
REQ-009 av_waitrequest  output  1  host stall; combinational.
REQ-010 vcount  input  10  current line from vga_counters.
REQ-011 ppu_chipselect  output  1  select to ppu.
REQ-012 ppu_write  output  1  write strobe to ppu.
REQ-013 ppu_address  output  16  address to ppu.
REQ-014 ppu_writedata  output  32  data to ppu.
REQ-015 fifo_level  output  $clog2(DEPTH)+1  entries queued.
REQ-016 frame_done  output  1  one-cycle pulse when a committed batch has fully drained.

Function
REQ-017 A host write SHALL be a control write when av_address[9:8]==2'b11, otherwise a queued write.
REQ-018 Control write fields SHALL be: bit0 immediate-mode enable, registered; bit1 commit strobe, self-clearing.
REQ-019 Control writes SHALL never stall and SHALL never enter the FIFO.
REQ-020 A queued write SHALL push {av_address, av_writedata} when av_chipselect & av_write & !full.
REQ-021 av_waitrequest SHALL equal av_chipselect & av_write & full & queued-target; the host holds the request until it is accepted.
REQ-022 A push and a pop in the same cycle SHALL both occur, leaving fifo_level unchanged; push on full or pop on empty SHALL never occur.
REQ-023 Commit SHALL load commit_left with fifo_level minus that cycle's pop, excluding any same-cycle push; a commit during ARMED or DRAIN SHALL overwrite commit_left the same way.
REQ-024 States:
- IDLE: commit_left==0.
- ARMED: commit_left>0, outside the window.
- DRAIN: commit_left>0, inside the window.
REQ-025 Drain window SHALL be vcount>=VACTIVE.
REQ-026 In DRAIN, one entry SHALL pop per cycle and commit_left SHALL decrement by one per pop.
REQ-027 When commit_left reaches 0, the machine SHALL go to IDLE and pulse frame_done the following cycle.
REQ-028 If the window closes (vcount wraps to 0) with commit_left>0, DRAIN SHALL go to ARMED, popping stops, and draining resumes at the next window.
REQ-029 A commit with zero eligible entries SHALL pulse frame_done on the next cycle, and the state SHALL remain IDLE.
REQ-030 When immediate mode is 1, an entry SHALL pop every cycle the FIFO is non-empty, regardless of state or window; each pop SHALL also decrement commit_left while it is >0.
REQ-031 A pop SHALL register the entry onto ppu_address/ppu_writedata with ppu_chipselect=ppu_write=1 for exactly one cycle; latency from pop decision to strobe is 1 cycle.
REQ-032 When not popping, ppu_chipselect and ppu_write SHALL be 0, and ppu_address/ppu_writedata SHALL hold their last value.
REQ-033 FIFO order SHALL be strict FIFO, and pointers SHALL wrap modulo DEPTH.

Reset
REQ-034 On reset, the block SHALL clear the FIFO (level 0), set commit_left=0, state=IDLE and immediate mode=0.
REQ-035 On reset, all outputs SHALL be 0, including ppu_address and ppu_writedata.
REQ-036 A reset asserted mid-drain SHALL discard all queued entries without issuing a partial ppu strobe after reset release.

Structure
REQ-037 Shared package ppu_pkg SHALL hold:
- the state enum {IDLE, ARMED, DRAIN};
- the region constants ATTR=2'b00, SPRITE=2'b01, COLOR=2'b10, CTRL=2'b11;
- the control bit indices.
REQ-038 Storage SHALL be the sub-module sync_fifo (width 48, depth DEPTH, full/empty/level); scheduling logic stays in ppu_write_sched.

Verification
REQ-039 Three queued writes (0x0001, 0x0102, 0x0203) then commit at vcount=100 -> no ppu strobe until vcount=480, then three consecutive strobes in order, frame_done pulses one cycle after the last.
REQ-040 DEPTH=8 full plus a 9th write -> av_waitrequest=1 until the first pop, then the write is accepted and fifo_level returns to 8.
REQ-041 Commit 5 entries with the window closing after 2 pops -> state ARMED, 3 remain, and the remaining 3 drain at the next vcount=480.
REQ-042 Immediate mode=1 with a single write to 0x0205 -> ppu strobe with address 0x0205 two cycles after acceptance, with no commit required.
REQ-043 Commit with an empty FIFO -> frame_done pulses on the next cycle and no ppu strobe occurs.
REQ-044 Reset asserted during DRAIN with 4 entries left -> fifo_level=0, all outputs 0, and no strobe after release.
